alu_result_stage: RTL and testbench
===================================

// Module: alu_result_stage
// PURPOSE
//  Downstream stage of the 8-bit ALU. Captures each ALU result (16-bit value, carry/borrow, opcode).
//  Derives a status-flag nibble for each result.
//  Buffers results in a DEPTH-entry FIFO and presents them to the consumer over a valid/ready handshake.
//  Decouples the combinational ALU from a back-pressuring writeback/consumer.
// PARAMETERS
//  DEPTH   4   FIFO entries; power of two, >=2
//  RES_W   16  result width; matches ALU output width
// PORTS
//  clk         in   1      single clock, rising edge
//  rst_n       in   1      asynchronous active-low reset
//  in_valid    in   1      ALU result valid this cycle
//  in_ready    out  1      stage can accept (= count != DEPTH)
//  in_result   in   RES_W  ALU result
//  in_cout     in   1      ALU carry/borrow
//  in_opcode   in   3      opcode that produced in_result
//  out_valid   out  1      head entry valid (= count != 0)
//  out_ready   in   1      consumer accepts head
//  out_result  out  RES_W  head result
//  out_opcode  out  3      head opcode
//  out_flags   out  4      head flags {C,Z,N,W}
//  (ALU_STATS_EN only) stats_clr in 1; op_count out 16; carry_count out 16
// BEHAVIOUR
//  - Reset (async assert, sync release): FIFO empty, rd/wr ptrs and count = 0.
//    out_valid=0, in_ready=1, out_result/out_opcode/out_flags=0.
//  - Push when in_valid&&in_ready; pop when out_valid&&out_ready.
//  - Flags are computed at push, combinationally from the inputs, and stored with the entry:
//      C = in_cout
//      Z = (in_result == 0), all RES_W bits
//      N = in_result[15] for MUL (3'b010); in_result[7] otherwise
//      W = |in_result[15:8] for non-MUL ops; 0 for MUL
//  - Latency: an entry pushed in cycle t is visible on out_* in cycle t+1 (registered storage, no bypass).
//  - out_* are driven from the head entry; they hold stable while out_valid && !out_ready.
//  - in_ready depends only on count. There is no combinational path from out_ready to in_ready.
//  - Full: in_ready=0; in_valid is ignored and no entry is overwritten.
//    Push and pop in the same cycle while full is therefore impossible.
//  - Empty: out_valid=0; out_ready is ignored; out_* hold their last popped values (0 after reset).
//  - Simultaneous push and pop (0<count<DEPTH): count unchanged, both pointers advance.
//  - Pointers are log2(DEPTH) bits and wrap modulo DEPTH. count is log2(DEPTH)+1 bits.
//  - Reset asserted mid-transfer: all buffered entries are discarded; no partial output is produced.
// CONFIGURATION
//  `ALU_STATS_EN defined:
//    - op_count increments on every push; carry_count increments on every push with in_cout=1.
//    - Both counters saturate at 16'hFFFF.
//    - stats_clr (synchronous) zeroes both counters and wins over a same-cycle increment.
//    - Both counters reset to 0.
//  `ALU_STATS_EN undefined:
//    - stats_clr, op_count and carry_count ports do not exist; no counter logic is built.
// STRUCTURE
//  - Shared package alu_pkg:
//      opcode constants OP_ADD..OP_XOR (3'b000..3'b111)
//      flag bit indices FLAG_C=3, FLAG_Z=2, FLAG_N=1, FLAG_W=0
//      typedef alu_res_t {result, opcode, flags}
//  - Sub-module alu_result_fifo: generic DEPTH x WIDTH synchronous FIFO with count, full/empty.
//  - Flag derivation and the optional counters live in alu_result_stage.
// TESTING
//  1 Reset, then push ADD result 16'h0105, cout=1, out_ready=1.
//    -> next cycle out_valid=1, out_result=16'h0105, out_flags=4'b1001.
//  2 Push SUB result 16'h0000, cout=0. -> out_flags=4'b0100 (Z only).
//    Push MUL result 16'h8000. -> out_flags=4'b0010 (N only, W=0).
//  3 out_ready=0; push 5 results 1..5. -> in_ready=0 after the 4th.
//    The 5th is dropped; drain yields 1,2,3,4 in order.
//  4 count=2; push and pop in the same cycle, repeated over 8 cycles.
//    -> count stays 2, order preserved across pointer wrap.
//  5 count=3; assert rst_n=0 mid-cycle. -> out_valid=0 and in_ready=1 immediately; no stale entry after release.
//  6 (ALU_STATS_EN) 70000 pushes, half with cout=1.
//    -> op_count saturates at 16'hFFFF, carry_count=35000. stats_clr -> both 0.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared ALU result-stage types and constants.
// Opcode encodings, flag bit positions and the buffered entry layout.
package alu_pkg;

    localparam int ALU_RES_W = 16;

    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_SUB = 3'b001;
    localparam logic [2:0] OP_MUL = 3'b010;
    localparam logic [2:0] OP_AND = 3'b011;
    localparam logic [2:0] OP_OR  = 3'b100;
    localparam logic [2:0] OP_SHL = 3'b101;
    localparam logic [2:0] OP_SHR = 3'b110;
    localparam logic [2:0] OP_XOR = 3'b111;

    localparam int FLAG_C = 3;
    localparam int FLAG_Z = 2;
    localparam int FLAG_N = 1;
    localparam int FLAG_W = 0;

    typedef struct packed {
        logic [ALU_RES_W-1:0] result;
        logic [2:0]           opcode;
        logic [3:0]           flags;
    } alu_res_t;

endpackage

// File: rtl/alu_result_fifo.sv
// Generic DEPTH x WIDTH synchronous FIFO with occupancy count.
// Head is read straight from registered storage; no write-to-read bypass.
module alu_result_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 8
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       wrEn,
    input  logic [WIDTH-1:0]           wrData,
    input  logic                       rdEn,
    output logic [WIDTH-1:0]           rdData,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       full,
    output logic                       empty
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wrPtr;
    logic [AW-1:0]    rdPtr;
    logic             wrOk;
    logic             rdOk;

    assign full   = (count == (AW+1)'(DEPTH));
    assign empty  = (count == '0);
    assign wrOk   = wrEn && !full;
    assign rdOk   = rdEn && !empty;
    assign rdData = mem[rdPtr];

    // Storage write; a full FIFO never overwrites an entry
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else if (wrOk) begin
            mem[wrPtr] <= wrData;
        end
    end

    // Pointers wrap naturally since DEPTH is a power of two
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wrPtr <= '0;
            rdPtr <= '0;
        end else begin
            if (wrOk) wrPtr <= wrPtr + 1'b1;
            if (rdOk) rdPtr <= rdPtr + 1'b1;
        end
    end

    // Occupancy tracks push/pop; simultaneous push and pop holds it
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else begin
            unique case ({wrOk, rdOk})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/alu_result_stage.sv
// ALU result stage: derives {C,Z,N,W} flags and buffers results in a FIFO.
// Optional push/carry statistics counters are built when ALU_STATS_EN is defined.
module alu_result_stage
    import alu_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int RES_W = ALU_RES_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [RES_W-1:0] in_result,
    input  logic             in_cout,
    input  logic [2:0]       in_opcode,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [RES_W-1:0] out_result,
    output logic [2:0]       out_opcode,
    output logic [3:0]       out_flags
`ifdef ALU_STATS_EN
    ,
    input  logic             stats_clr,
    output logic [15:0]      op_count,
    output logic [15:0]      carry_count
`endif
);

    localparam int CW = $clog2(DEPTH) + 1;

    logic           push;
    logic           pop;
    logic           isMul;
    logic [3:0]     flags;
    alu_res_t       wrEntry;
    alu_res_t       headEntry;
    alu_res_t       lastEntry;
    alu_res_t       outEntry;
    logic [CW-1:0]  count;
    logic           full;
    logic           empty;

    assign in_ready  = !full;
    assign out_valid = (count != '0);
    assign push      = in_valid && in_ready;
    assign pop       = out_valid && out_ready;

    // Flags derived from the incoming result, stored alongside it
    always_comb begin
        isMul         = (in_opcode == OP_MUL);
        flags         = '0;
        flags[FLAG_C] = in_cout;
        flags[FLAG_Z] = (in_result == '0);
        flags[FLAG_N] = isMul ? in_result[RES_W-1] : in_result[7];
        flags[FLAG_W] = isMul ? 1'b0 : |in_result[RES_W-1:8];
        wrEntry       = '{result: in_result, opcode: in_opcode, flags: flags};
    end

    alu_result_fifo #(
        .DEPTH(DEPTH),
        .WIDTH($bits(alu_res_t))
    ) uFifo (
        .clk    (clk),
        .rst_n  (rst_n),
        .wrEn   (push),
        .wrData (wrEntry),
        .rdEn   (pop),
        .rdData (headEntry),
        .count  (count),
        .full   (full),
        .empty  (empty)
    );

    // Remember the last popped entry so outputs hold while empty
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) lastEntry <= '0;
        else if (pop) lastEntry <= headEntry;
    end

    // Head entry when present, otherwise the last value handed out
    always_comb begin
        outEntry   = empty ? lastEntry : headEntry;
        out_result = outEntry.result;
        out_opcode = outEntry.opcode;
        out_flags  = outEntry.flags;
    end

`ifdef ALU_STATS_EN
    // Saturating push and carry counters; clear wins over increment
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_count    <= '0;
            carry_count <= '0;
        end else if (stats_clr) begin
            op_count    <= '0;
            carry_count <= '0;
        end else if (push) begin
            if (op_count != 16'hFFFF) op_count <= op_count + 1'b1;
            if (in_cout && carry_count != 16'hFFFF)
                carry_count <= carry_count + 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_alu_result_stage.sv
// Scoreboard bench for alu_result_stage with directed vectors.
// Define ALU_STATS_EN to also exercise the statistics counters.
module tb_alu_result_stage;
    import alu_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [15:0] in_result = '0;
    logic        in_cout = 1'b0;
    logic [2:0]  in_opcode = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [15:0] out_result;
    logic [2:0]  out_opcode;
    logic [3:0]  out_flags;
`ifdef ALU_STATS_EN
    logic        stats_clr = 1'b0;
    logic [15:0] op_count;
    logic [15:0] carry_count;
`endif

    int compared = 0;
    int mismatched = 0;
    bit monEn = 1'b1;
    alu_res_t q[$];

    always #5 clk = ~clk;

    alu_result_stage dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_result  (in_result),
        .in_cout    (in_cout),
        .in_opcode  (in_opcode),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_result (out_result),
        .out_opcode (out_opcode),
        .out_flags  (out_flags)
`ifdef ALU_STATS_EN
        ,
        .stats_clr  (stats_clr),
        .op_count   (op_count),
        .carry_count(carry_count)
`endif
    );

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: every accepted output is compared with the queue head
    always @(negedge clk) begin
        if (rst_n && monEn && out_valid && out_ready) begin
            if (q.size() == 0) begin
                compared++;
                mismatched++;
                $display("FAIL sb_unexpected: got %0h expected none", out_result);
            end else begin
                alu_res_t e;
                e = q.pop_front();
                check("sb_result", 32'(out_result), 32'(e.result));
                check("sb_opcode", 32'(out_opcode), 32'(e.opcode));
                check("sb_flags", 32'(out_flags), 32'(e.flags));
            end
        end
    end

    // One push attempt; expectation queued only if the DUT accepts it
    task automatic push(input logic [15:0] res, input logic cout,
                        input logic [2:0] op, input logic [3:0] expFlags);
        in_valid  = 1'b1;
        in_result = res;
        in_cout   = cout;
        in_opcode = op;
        @(negedge clk);
        if (in_ready) q.push_back('{result: res, opcode: op, flags: expFlags});
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        #12;
        check("rst_out_valid", 32'(out_valid), 0);
        check("rst_in_ready", 32'(in_ready), 1);
        check("rst_out_result", 32'(out_result), 0);
        check("rst_out_opcode", 32'(out_opcode), 0);
        check("rst_out_flags", 32'(out_flags), 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
`ifdef ALU_STATS_EN
        check("rst_op_count", 32'(op_count), 0);
        check("rst_carry_count", 32'(carry_count), 0);
`endif

        // 1: ADD, latency one cycle
        out_ready = 1'b1;
        push(16'h0105, 1'b1, OP_ADD, 4'b1001);
        check("t1_out_valid", 32'(out_valid), 1);
        check("t1_out_result", 32'(out_result), 32'h0105);
        check("t1_out_flags", 32'(out_flags), 32'b1001);
        idle(2);

        // 2: flag patterns
        push(16'h0000, 1'b0, OP_SUB, 4'b0100);
        push(16'h8000, 1'b0, OP_MUL, 4'b0010);
        push(16'h0080, 1'b0, OP_AND, 4'b0010);
        push(16'h1234, 1'b1, OP_OR,  4'b1001);
        push(16'hFF00, 1'b0, OP_MUL, 4'b0010);
        push(16'h00FF, 1'b0, OP_XOR, 4'b0010);
        idle(3);

        // 3: fill under back-pressure; fifth push dropped
        out_ready = 1'b0;
        for (int i = 1; i <= 5; i++) begin
            push(16'(i), 1'b0, OP_ADD, 4'b0000);
            if (i == 4) check("t3_full_in_ready", 32'(in_ready), 0);
            if (i == 3) check("t3_notfull_in_ready", 32'(in_ready), 1);
        end
        check("t3_hold_result", 32'(out_result), 1);
        out_ready = 1'b1;
        idle(6);
        check("t3_empty_valid", 32'(out_valid), 0);
        check("t3_hold_last", 32'(out_result), 4);

        // 4: count held at 2 with push+pop across pointer wrap
        out_ready = 1'b0;
        push(16'h0A00, 1'b0, OP_SUB, 4'b0001);
        push(16'h0B00, 1'b1, OP_SUB, 4'b1001);
        out_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            logic [3:0] ii;
            ii = 4'(i);
            push(16'h0100 | 16'(i), ii[0], OP_SUB, {ii[0], 3'b001});
            check("t4_in_ready", 32'(in_ready), 1);
        end
        idle(1);
        check("t4_one_left", 32'(out_valid), 1);
        idle(1);
        check("t4_drained", 32'(out_valid), 0);

        // 5: reset mid-transfer discards buffered entries
        out_ready = 1'b0;
        push(16'h0011, 1'b0, OP_ADD, 4'b0000);
        push(16'h0022, 1'b0, OP_ADD, 4'b0000);
        push(16'h0033, 1'b0, OP_ADD, 4'b0000);
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("t5_rst_valid", 32'(out_valid), 0);
        check("t5_rst_ready", 32'(in_ready), 1);
        check("t5_rst_result", 32'(out_result), 0);
        q.delete();
        @(posedge clk);
        #2;
        rst_n = 1'b1;
        out_ready = 1'b1;
        idle(2);
        check("t5_no_stale", 32'(out_valid), 0);
        push(16'h0044, 1'b1, OP_SHL, 4'b1000);
        idle(3);
        check("sb_leftover", 32'(q.size()), 0);

`ifdef ALU_STATS_EN
        // 6: saturation and clear of statistics
        monEn = 1'b0;
        rst_n = 1'b0;
        #2;
        rst_n = 1'b1;
        q.delete();
        idle(1);
        out_ready = 1'b1;
        in_valid = 1'b1;
        in_opcode = OP_ADD;
        for (int i = 0; i < 70000; i++) begin
            in_cout = (i % 2) == 1;
            in_result = 16'(i);
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        in_cout = 1'b0;
        check("t6_op_sat", 32'(op_count), 32'hFFFF);
        check("t6_carry", 32'(carry_count), 35000);
        stats_clr = 1'b1;
        in_valid = 1'b1;
        in_cout = 1'b1;
        idle(1);
        stats_clr = 1'b0;
        in_valid = 1'b0;
        check("t6_clr_op", 32'(op_count), 0);
        check("t6_clr_carry", 32'(carry_count), 0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: got no finish expected finish");
        $fatal(1, "timeout");
    end

endmodule
